// File: rtl/shifter_pkg.sv
// shifter_pkg: shared types and defaults for the shifter/deserializer family
package shifter_pkg;
  typedef enum logic {DIR_MSB_FIRST = 1'b0, DIR_LSB_FIRST = 1'b1} shift_dir_e;
  typedef enum logic {ST_IDLE, ST_SHIFT} deser_state_e;
  localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/deser_shift_reg.sv
// deser_shift_reg: bidirectional serial-in shift register with shift-into-zero on clr
module deser_shift_reg
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  shift_dir_e       dir,
  input  logic             din,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] base;
  assign base = clr ? '0 : q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= (dir == DIR_LSB_FIRST) ? {din, base[WIDTH-1:1]} : {base[WIDTH-2:0], din};
    else if (clr) q <= '0;
endmodule

// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-in/parallel-out receiver with a one-word valid/ready output buffer
module shift_deserializer
  import shifter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin_valid,
  input  logic             sin_bit,
  input  logic             sin_lsb_first,
  input  logic             clear,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun
);
  localparam int CW = $clog2(WIDTH);
  logic [CW-1:0] cnt;
  deser_state_e state;
  shift_dir_e dir;
  logic [WIDTH-1:0] q, word;
  logic idle, done;
  assign idle = state == ST_IDLE;
  assign done = sin_valid && cnt == CW'(WIDTH - 1);
  // completion word is the register contents with the final bit shifted in
  assign word = (dir == DIR_LSB_FIRST) ? {sin_bit, q[WIDTH-1:1]} : {q[WIDTH-2:0], sin_bit};
  assign busy = state == ST_SHIFT;
  deser_shift_reg #(.WIDTH(WIDTH)) u_sreg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (sin_valid && !clear),
    .clr  (clear || idle),
    .dir  (idle ? shift_dir_e'(sin_lsb_first) : dir),
    .din  (sin_bit),
    .q    (q)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt        <= '0;
      state      <= ST_IDLE;
      dir        <= DIR_MSB_FIRST;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      cnt        <= '0;
      state      <= ST_IDLE;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (sin_valid) begin
        if (idle) dir <= shift_dir_e'(sin_lsb_first);
        cnt   <= done ? '0 : cnt + 1'b1;
        state <= done ? ST_IDLE : ST_SHIFT;
      end
      if (done && (!dout_valid || dout_ready)) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (done) overrun <= 1'b1;
      else if (dout_valid && dout_ready) dout_valid <= 1'b0;
    end
endmodule
